// File: rtl/cfu_pipelined_fc.sv
// Pipelined multi-function CFU with ready/valid handshakes on both sides.
// Credits bound in-flight work to the response FIFO, so the pipeline never stalls.
module cfu_pipelined_fc #(
    parameter int CFU_FUNCTION_ID_W = 16,
    parameter int CFU_REQ_RESP_ID_W = 6,
    parameter int CFU_REQ_DATA_W    = 32,
    parameter int CFU_ERROR_ID_W    = 32,
    parameter int LATENCY           = 3,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clock_en,
    output logic                         req_ready,
    input  logic                         req_valid,
    input  logic [CFU_FUNCTION_ID_W-1:0] req_function_id,
    input  logic [CFU_REQ_RESP_ID_W-1:0] req_id,
    input  logic [2*CFU_REQ_DATA_W-1:0]  req_data,
    input  logic                         resp_ready,
    output logic                         resp_valid,
    output logic [CFU_REQ_RESP_ID_W-1:0] resp_id,
    output logic [CFU_REQ_DATA_W-1:0]    resp_data,
    output logic                         resp_ok,
    output logic [CFU_ERROR_ID_W-1:0]    resp_error_id
);

    localparam int W  = CFU_REQ_DATA_W;
    localparam int FW = CFU_FUNCTION_ID_W;
    localparam int IW = CFU_REQ_RESP_ID_W;
    localparam int EW = CFU_ERROR_ID_W;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int XW = (FW > EW) ? FW : EW;

    localparam logic [FW-1:0] FN_MUL   = FW'(0);
    localparam logic [FW-1:0] FN_MULHU = FW'(1);
    localparam logic [FW-1:0] FN_ADD   = FW'(2);
    localparam logic [FW-1:0] FN_SUB   = FW'(3);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic          ok;
        logic [EW-1:0] err;
    } resp_t;

    typedef struct packed {
        logic  valid;
        resp_t r;
    } slot_t;

    logic [CW-1:0]  count;
    logic [CW-1:0]  fcnt;
    logic [PW-1:0]  rptr;
    logic [PW-1:0]  wptr;
    logic           accept;
    logic           pop;
    logic           wr_en;
    logic [W-1:0]   op0;
    logic [W-1:0]   op1;
    logic [2*W-1:0] prod;
    logic [XW-1:0]  fn_ext;
    logic           is_mul;
    logic           is_mulhu;
    logic           is_add;
    logic           is_sub;
    slot_t          in_slot;
    slot_t          wr_slot;
    resp_t          head;
    resp_t          mem [FIFO_DEPTH];

    assign req_ready  = count < CW'(FIFO_DEPTH);
    assign resp_valid = fcnt != '0;
    assign accept     = clock_en & req_valid & req_ready;
    assign pop        = clock_en & resp_valid & resp_ready;

    assign op0    = req_data[W-1:0];
    assign op1    = req_data[2*W-1:W];
    assign prod   = (2*W)'(op0) * (2*W)'(op1);
    assign fn_ext = XW'(req_function_id);

    assign is_mul   = req_function_id == FN_MUL;
    assign is_mulhu = req_function_id == FN_MULHU;
    assign is_add   = req_function_id == FN_ADD;
    assign is_sub   = req_function_id == FN_SUB;

    // Result is formed at accept time; the stages only carry it.
    always_comb begin
        in_slot       = '0;
        in_slot.valid = accept;
        in_slot.r.id  = req_id;
        in_slot.r.ok  = 1'b1;
        unique case (1'b1)
            is_mul:   in_slot.r.data = prod[W-1:0];
            is_mulhu: in_slot.r.data = prod[2*W-1:W];
            is_add:   in_slot.r.data = op0 + op1;
            is_sub:   in_slot.r.data = op0 - op1;
            default: begin
                in_slot.r.ok  = 1'b0;
                in_slot.r.err = fn_ext[EW-1:0];
            end
        endcase
    end

    if (LATENCY == 1) begin : g_direct
        assign wr_slot = in_slot;
    end else begin : g_pipe
        slot_t stg [LATENCY-1];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    stg[i] <= '0;
                end
            end else if (clock_en) begin
                stg[0] <= in_slot;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    stg[i] <= stg[i-1];
                end
            end
        end

        assign wr_slot = stg[LATENCY-2];
    end

    assign wr_en = clock_en & wr_slot.valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            fcnt  <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else if (clock_en) begin
            count <= count + CW'(accept) - CW'(pop);
            fcnt  <= fcnt + CW'(wr_en) - CW'(pop);
            if (wr_en) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
        end
    end

    // Credits guarantee a free entry whenever the last stage is valid.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem[wptr] <= wr_slot.r;
        end
    end

    assign head = mem[rptr];

    always_comb begin
        resp_id       = '0;
        resp_data     = '0;
        resp_ok       = 1'b1;
        resp_error_id = '0;
        if (resp_valid) begin
            resp_id       = head.id;
            resp_data     = head.data;
            resp_ok       = head.ok;
            resp_error_id = head.err;
        end
    end

endmodule

// File: doc/cfu_pipelined_fc.md
Name: cfu_pipelined_fc

Overview:
- Next-generation pipelined CFU. Supports full ready/valid flow control on both request and response sides.
- Generalises the fixed 3-stage multiply-only pipelined CFU:
  - parametrised latency;
  - a multi-function datapath;
  - error responses for unsupported function IDs;
  - a credit-controlled output FIFO, so the pipeline never stalls on resp_ready.
- Sits between the CPU CFU dispatch port and the response writeback path.
- Directly implements the general CFU request/response handshake. No separate adapter is needed.

Parameters:
- CFU_FUNCTION_ID_W, 16, function ID width.
- CFU_REQ_RESP_ID_W, 6, request/response correlation ID width.
- CFU_REQ_DATA_W, 32, operand width W. Responses are also W bits.
- CFU_ERROR_ID_W, 32, error ID width.
- LATENCY, 3, request-accept to earliest resp_valid, in cycles. Legal range ≥1.
- FIFO_DEPTH, 4, response FIFO entries and credit limit. Legal range ≥1. Full throughput requires FIFO_DEPTH ≥ LATENCY+1.

Ports:
- clock  in  1  Single clock. All state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- clock_en  in  1  Global enable. When low, no state changes.
- req_ready  out  1  Slot available. Equals (count < FIFO_DEPTH). Derived from registers only.
- req_valid  in  1  Request valid.
- req_function_id  in  CFU_FUNCTION_ID_W  Operation select.
- req_id  in  CFU_REQ_RESP_ID_W  Request tag, returned unchanged on resp_id.
- req_data  in  2*W  Operand 0 in [W-1:0], operand 1 in [2W-1:W].
- resp_ready  in  1  Consumer accepts the response.
- resp_valid  out  1  FIFO non-empty.
- resp_id  out  CFU_REQ_RESP_ID_W  Tag of the head response.
- resp_data  out  W  Result of the head response.
- resp_ok  out  1  1 = success, 0 = unsupported function.
- resp_error_id  out  CFU_ERROR_ID_W  Error detail.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clock, reset). Reset has priority over clock_en.
- Reset state:
  - all pipeline valids cleared, FIFO empty, count=0;
  - outputs: req_ready=1, resp_valid=0, resp_id=0, resp_data=0, resp_ok=1, resp_error_id=0.
- Reset mid-operation discards all in-flight and queued responses. They are never delivered.
- Handshakes:
  - accept = clock_en & req_valid & req_ready.
  - pop = clock_en & resp_valid & resp_ready.
  - With clock_en=0, neither event occurs, whatever the levels of valid/ready.
- Credit counter: count (width clog2(FIFO_DEPTH+1)) = requests accepted but not yet popped, including those still in the pipeline.
  - count_next = count + accept − pop.
  - Simultaneous accept and pop leaves count unchanged.
  - count never exceeds FIFO_DEPTH, so a FIFO write can never overflow.
- Pipeline:
  - LATENCY−1 register stages, each holding {valid, id, data, ok, err}.
  - The result is computed combinationally at the input, when the request is accepted.
  - The last stage writes into the FIFO when its valid is set. With LATENCY=1, the computed result is written into the FIFO on the accept edge.
  - Stages advance on every clock_en=1 cycle and never depend on resp_ready. Bubbles (valid=0) advance too.
- FIFO:
  - Circular buffer, FIFO_DEPTH entries, with wrapping read and write pointers.
  - Head is presented combinationally from storage (first-word fall-through).
  - Same-cycle write into an empty FIFO becomes visible on the next cycle, not on the same cycle.
- Latency and ordering:
  - Request accepted at cycle t → resp_valid=1 at cycle t+LATENCY at the earliest.
  - Responses are returned strictly in acceptance order.
- resp_* when resp_valid=0: forced to the reset values listed above.
- Functions (all arithmetic modulo 2^W, unsigned):
  - 0: MUL, low W bits of op0*op1.
  - 1: MULHU, high W bits of the 2W-bit product op0*op1.
  - 2: ADD, op0+op1.
  - 3: SUB, op0−op1.
- Any other function ID:
  - resp_ok=0, resp_data=0;
  - resp_error_id = req_function_id, zero-extended or truncated to CFU_ERROR_ID_W;
  - takes the same latency and the same slot as a valid request.
- Valid functions return resp_ok=1, resp_error_id=0.
- Throughput:
  - With FIFO_DEPTH ≥ LATENCY+1 and resp_ready held at 1, one request is accepted per cycle indefinitely.
  - With a smaller FIFO_DEPTH, req_ready drops periodically. Results remain correct.
- Stall with clock_en=0: count, pipeline, FIFO and outputs hold. req_ready and resp_valid keep their values.

Test Plan:
- Reset, then one request {fn=0, id=5, op0=7, op1=6} at t0 → resp_valid first high at t0+3 with resp_id=5, resp_data=42, resp_ok=1. Next cycle resp_valid=0 (resp_ready=1).
- Back-to-back with resp_ready=1: fn=1 with op0=op1=0xFFFFFFFF → 0xFFFFFFFE. Then fn=2 with 0xFFFFFFFF+2 → 0x00000001. Then fn=3 with 3−5 → 0xFFFFFFFE. req_ready stays 1 throughout; responses arrive on consecutive cycles, in order.
- fn=0x1234, id=9 → resp_ok=0, resp_data=0, resp_error_id=0x00001234, id=9, same latency.
- resp_ready=0 while issuing continuous requests → exactly 4 accepted, then req_ready=0. Raise resp_ready → 4 responses in order; req_ready returns to 1 the cycle after the first pop.
- clock_en=0 for 5 cycles with 2 requests in flight → no outputs change. After re-enable, responses appear 5 cycles later than otherwise, with their data intact.
- Assert reset with 3 responses queued → next cycle resp_valid=0, req_ready=1. A fresh request returns only its own response.
